// File: rtl/ram_stream_reader_if.sv
// Command, RAM read-port and output-stream signals of ram_stream_reader.
// master = the reader itself, slave = the surrounding logic (command source, RAM, sink).
interface ram_stream_reader_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 5
);
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic [ADDR_WIDTH-1:0] cmd_addr_i;
    logic [ADDR_WIDTH-1:0] cmd_len_i;
    logic                  ram_rd_o;
    logic [ADDR_WIDTH-1:0] ram_rd_addr_o;
    logic                  ram_output_reg_en_o;
    logic [DATA_WIDTH-1:0] ram_rd_data_i;
    logic [DATA_WIDTH-1:0] tdata_o;
    logic                  tvalid_o;
    logic                  tready_i;
    logic                  tlast_o;
    logic                  busy_o;

    modport master (
        input  cmd_valid_i, cmd_addr_i, cmd_len_i, ram_rd_data_i, tready_i,
        output cmd_ready_o, ram_rd_o, ram_rd_addr_o, ram_output_reg_en_o,
        output tdata_o, tvalid_o, tlast_o, busy_o
    );

    modport slave (
        output cmd_valid_i, cmd_addr_i, cmd_len_i, ram_rd_data_i, tready_i,
        input  cmd_ready_o, ram_rd_o, ram_rd_addr_o, ram_output_reg_en_o,
        input  tdata_o, tvalid_o, tlast_o, busy_o
    );
endinterface

// File: rtl/ram_stream_reader.sv
// Read-side master for dual_port_ram: (addr, len) command in, valid/ready stream out.
// Optional abort_i port enabled by defining RAM_READER_ABORT_EN.
module ram_stream_reader #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH  = 5,
    parameter int unsigned RAM_LATENCY = 1
) (
    input  logic clk_i,
    input  logic rst_n_i,
`ifdef RAM_READER_ABORT_EN
    input  logic abort_i,
`endif
    ram_stream_reader_if.master bus
);
    localparam int unsigned DEPTH   = RAM_LATENCY + 1;
    localparam logic [2:0]  DEPTH_C = 3'(DEPTH);

    if (RAM_LATENCY != 1 && RAM_LATENCY != 2) begin : g_bad_latency
        $error("ram_stream_reader: RAM_LATENCY must be 1 or 2");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                  state;
    logic                    alive;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [ADDR_WIDTH-1:0]   remaining;
    logic [RAM_LATENCY-1:0]  inflight_v;
    logic [RAM_LATENCY-1:0]  inflight_last;
    logic [DATA_WIDTH-1:0]   buf_data   [DEPTH];
    logic [DATA_WIDTH-1:0]   buf_data_n [DEPTH];
    logic [DEPTH-1:0]        buf_last;
    logic [DEPTH-1:0]        buf_last_n;
    logic [2:0]              count;
    logic [2:0]              count_n;
    logic [2:0]              occ_after_pop;
    logic [2:0]              inflight_cnt;
    logic                    cmd_ready;
    logic                    pop;
    logic                    push;
    logic                    credit_ok;
    logic                    rd_fire;
    logic                    abort_now;

    always_comb begin
`ifdef RAM_READER_ABORT_EN
        abort_now = abort_i && (state != IDLE);
`else
        abort_now = 1'b0;
`endif
    end

    // Occupancy is taken after this cycle's pop so a steady stream never stalls on credit.
    always_comb begin
        cmd_ready     = alive && (state == IDLE);
        pop           = (count != 3'd0) && bus.tready_i;
        push          = inflight_v[RAM_LATENCY-1];
        occ_after_pop = count - {2'b00, pop};
        inflight_cnt  = '0;
        for (int unsigned i = 0; i < RAM_LATENCY; i++) begin
            inflight_cnt = inflight_cnt + {2'b00, inflight_v[i]};
        end
        credit_ok = (occ_after_pop + inflight_cnt + 3'd1) <= DEPTH_C;
        rd_fire   = (state == ISSUE) && credit_ok && !abort_now;
    end

    always_comb begin
        buf_data_n = buf_data;
        buf_last_n = buf_last;
        count_n    = count;
        if (pop) begin
            for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                buf_data_n[i] = buf_data[i+1];
                buf_last_n[i] = buf_last[i+1];
            end
            buf_data_n[DEPTH-1] = '0;
            buf_last_n[DEPTH-1] = 1'b0;
            count_n = count - 3'd1;
        end
        if (push) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (count_n == 3'(i)) begin
                    buf_data_n[i] = bus.ram_rd_data_i;
                    buf_last_n[i] = inflight_last[RAM_LATENCY-1];
                end
            end
            count_n = count_n + 3'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state         <= IDLE;
            alive         <= 1'b0;
            rd_addr       <= '0;
            remaining     <= '0;
            inflight_v    <= '0;
            inflight_last <= '0;
            count         <= '0;
            buf_last      <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                buf_data[i] <= '0;
            end
        end else begin
            alive            <= 1'b1;
            inflight_v[0]    <= rd_fire;
            inflight_last[0] <= rd_fire && (remaining == '0);
            for (int unsigned i = 1; i < RAM_LATENCY; i++) begin
                inflight_v[i]    <= inflight_v[i-1];
                inflight_last[i] <= inflight_last[i-1];
            end
            buf_data <= buf_data_n;
            buf_last <= buf_last_n;
            count    <= count_n;

            case (state)
                IDLE: begin
                    if (bus.cmd_valid_i && cmd_ready) begin
                        rd_addr   <= bus.cmd_addr_i;
                        remaining <= bus.cmd_len_i;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (rd_fire) begin
                        rd_addr   <= rd_addr + ADDR_WIDTH'(1);
                        remaining <= remaining - ADDR_WIDTH'(1);
                        if (remaining == '0) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && buf_last[0]) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Abort overrides everything above: pipeline and buffer are flushed together.
            if (abort_now) begin
                state      <= IDLE;
                inflight_v <= '0;
                count      <= '0;
                buf_last   <= '0;
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    buf_data[i] <= '0;
                end
            end
        end
    end

    assign bus.cmd_ready_o         = cmd_ready;
    assign bus.ram_rd_o            = rd_fire;
    assign bus.ram_rd_addr_o       = rd_addr;
    assign bus.ram_output_reg_en_o = alive;
    assign bus.tdata_o             = buf_data[0];
    assign bus.tvalid_o            = (count != 3'd0);
    assign bus.tlast_o             = buf_last[0];
    assign bus.busy_o              = (state != IDLE);

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader: instance 0 uses RAM_LATENCY=1, instance 1 RAM_LATENCY=2.
`timescale 1ns/1ps
module tb_ram_stream_reader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [32];

    logic       cmd_valid [2];
    logic [4:0] cmd_addr  [2];
    logic [4:0] cmd_len   [2];
    logic       tready    [2];
    logic       cmd_ready [2];
    logic       ram_rd    [2];
    logic [4:0] ram_addr  [2];
    logic       oreg_en   [2];
    logic [7:0] tdata     [2];
    logic       tvalid    [2];
    logic       tlast     [2];
    logic       busy      [2];
`ifdef RAM_READER_ABORT_EN
    logic       abort     [2];
`endif

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ram_stream_reader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) bus ();
        logic [7:0] q1;
        logic [7:0] q2;

        ram_stream_reader #(
            .DATA_WIDTH (8),
            .ADDR_WIDTH (5),
            .RAM_LATENCY(g + 1)
        ) u_dut (
            .clk_i  (clk),
            .rst_n_i(rst_n),
`ifdef RAM_READER_ABORT_EN
            .abort_i(abort[g]),
`endif
            .bus    (bus)
        );

        // Behavioural RAM read port: q1 is the array read, q2 the optional output register.
        always @(posedge clk) begin
            if (bus.ram_rd_o) q1 <= mem[bus.ram_rd_addr_o];
            if (bus.ram_output_reg_en_o) q2 <= q1;
        end

        assign bus.cmd_valid_i   = cmd_valid[g];
        assign bus.cmd_addr_i    = cmd_addr[g];
        assign bus.cmd_len_i     = cmd_len[g];
        assign bus.tready_i      = tready[g];
        assign bus.ram_rd_data_i = (g == 0) ? q1 : q2;
        assign cmd_ready[g] = bus.cmd_ready_o;
        assign ram_rd[g]    = bus.ram_rd_o;
        assign ram_addr[g]  = bus.ram_rd_addr_o;
        assign oreg_en[g]   = bus.ram_output_reg_en_o;
        assign tdata[g]     = bus.tdata_o;
        assign tvalid[g]    = bus.tvalid_o;
        assign tlast[g]     = bus.tlast_o;
        assign busy[g]      = bus.busy_o;
    end

    typedef struct {
        int          dut;
        logic [4:0]  addr;
        logic [4:0]  len;
        logic [15:0] rdy;
        int          span;
    } vec_t;

    vec_t vecs [9];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic wait_ready(input int d);
        for (int i = 0; i < 20 && !cmd_ready[d]; i++) begin
            @(posedge clk); #2;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int d, lat, nrd, nb, first_rd, first_v, lastk, max_out, prev_data;
        bit stalled;
        d = v.dut; lat = d + 1;
        nrd = 0; nb = 0; first_rd = -1; first_v = -1; lastk = -1;
        max_out = 0; prev_data = 0; stalled = 1'b0;
        wait_ready(d);
        check("cmd_ready_idle", cmd_ready[d], 1);
        cmd_valid[d] = 1'b1; cmd_addr[d] = v.addr; cmd_len[d] = v.len;
        tready[d] = v.rdy[0];
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            cmd_valid[d] = 1'b0;
            tready[d] = v.rdy[k % 16];
            #1;
            if (k == 1) check("busy_after_accept", busy[d], 1);
            if (stalled) begin
                check("stall_hold_valid", tvalid[d], 1);
                check("stall_hold_data", tdata[d], prev_data);
            end
            if (lastk >= 0) begin
                check("busy_after_last", busy[d], 0);
                check("ready_after_last", cmd_ready[d], 1);
                check("valid_after_last", tvalid[d], 0);
                break;
            end
            if (ram_rd[d]) begin
                if (first_rd < 0) first_rd = k;
                check("rd_addr", ram_addr[d], (v.addr + nrd) % 32);
                nrd++;
            end
            if (tvalid[d] && first_v < 0) first_v = k;
            if (tvalid[d] && tready[d]) begin
                check("beat_data", tdata[d], (v.addr + nb) % 32);
                check("beat_last", tlast[d], (nb == v.len) ? 1 : 0);
                if (nb == v.len) lastk = k;
                nb++;
            end
            stalled   = tvalid[d] && !tready[d];
            prev_data = tdata[d];
            if (nrd - nb > max_out) max_out = nrd - nb;
        end
        tready[d] = 1'b1;
        check("cmd_done", (lastk >= 0) ? 1 : 0, 1);
        check("beat_count", nb, v.len + 1);
        check("read_count", nrd, v.len + 1);
        check("first_rd_cycle", first_rd, 1);
        check("first_valid_cycle", first_v, lat + 2);
        check("outstanding_bounded", (max_out <= lat + 1) ? 1 : 0, 1);
        if (v.span > 0) check("last_beat_cycle", lastk, v.span);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, limit 200000 ns");
        $fatal(1);
    end

    initial begin
        int nb;
        vecs[0] = '{0, 5'd4,  5'd3,  16'hFFFF, 6};
        vecs[1] = '{0, 5'd30, 5'd3,  16'hFFFF, 6};
        vecs[2] = '{1, 5'd4,  5'd3,  16'hFFFF, 7};
        vecs[3] = '{1, 5'd30, 5'd3,  16'hFFFF, 7};
        vecs[4] = '{0, 5'd0,  5'd15, 16'b1010_0101_0010_1001, 0};
        vecs[5] = '{1, 5'd0,  5'd15, 16'b1010_0101_0010_1001, 0};
        vecs[6] = '{0, 5'd5,  5'd31, 16'hFFFF, 34};
        vecs[7] = '{1, 5'd0,  5'd0,  16'hFFFF, 4};
        vecs[8] = '{0, 5'd31, 5'd0,  16'hFFFF, 3};

        for (int i = 0; i < 32; i++) mem[i] = 8'(i);
        for (int d = 0; d < 2; d++) begin
            cmd_valid[d] = 1'b0; cmd_addr[d] = '0; cmd_len[d] = '0; tready[d] = 1'b1;
`ifdef RAM_READER_ABORT_EN
            abort[d] = 1'b0;
`endif
        end

        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_cmd_ready", cmd_ready[d], 0);
            check("rst_tvalid", tvalid[d], 0);
            check("rst_busy", busy[d], 0);
            check("rst_oreg_en", oreg_en[d], 0);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #2;
        for (int d = 0; d < 2; d++) begin
            check("oreg_en_running", oreg_en[d], 1);
            check("ready_after_reset", cmd_ready[d], 1);
        end

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Reset pulse while the third beat of a len=7 command is on the bus.
        wait_ready(0);
        cmd_valid[0] = 1'b1; cmd_addr[0] = 5'd0; cmd_len[0] = 5'd7; tready[0] = 1'b1;
        nb = 0;
        for (int k = 1; k <= 20 && nb < 3; k++) begin
            @(posedge clk); #1;
            cmd_valid[0] = 1'b0;
            #1;
            if (tvalid[0] && tready[0]) begin
                if (nb == 2) check("pre_reset_beat3", tdata[0], 2);
                nb++;
            end
        end
        check("pre_reset_beats", nb, 3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tvalid", tvalid[0], 0);
        check("mid_rst_tdata", tdata[0], 0);
        check("mid_rst_tlast", tlast[0], 0);
        check("mid_rst_ready", cmd_ready[0], 0);
        check("mid_rst_busy", busy[0], 0);
        check("mid_rst_rd", ram_rd[0], 0);
        check("mid_rst_rd_addr", ram_addr[0], 0);
        check("mid_rst_oreg_en", oreg_en[0], 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #2;
            check("post_rst_no_beat", tvalid[0], 0);
            check("post_rst_idle", busy[0], 0);
            check("post_rst_ready", cmd_ready[0], 1);
        end

`ifdef RAM_READER_ABORT_EN
        for (int d = 0; d < 2; d++) begin
            wait_ready(d);
            cmd_valid[d] = 1'b1; cmd_addr[d] = 5'd0; cmd_len[d] = 5'd9; tready[d] = 1'b1;
            nb = 0;
            for (int k = 1; k <= 30 && nb < 2; k++) begin
                @(posedge clk); #1;
                cmd_valid[d] = 1'b0;
                #1;
                if (tvalid[d] && tready[d]) nb++;
            end
            check("pre_abort_beats", nb, 2);
            @(posedge clk); #1;
            abort[d] = 1'b1;
            #1;
            check("abort_no_rd", ram_rd[d], 0);
            @(posedge clk); #1;
            abort[d] = 1'b0;
            #1;
            check("abort_tvalid", tvalid[d], 0);
            check("abort_ready", cmd_ready[d], 1);
            check("abort_busy", busy[d], 0);
            run_vec('{d, 5'd0, 5'd0, 16'hFFFF, d + 3});
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
